// File: rtl/riscv_pkg.sv
// Shared RISC-V bus-interface types and the memory arbiter state encoding.
package riscv_pkg;

    typedef enum logic [2:0] {
        BYTE       = 3'd0,
        HWORD      = 3'd1,
        WORD       = 3'd2,
        DWORD      = 3'd3,
        UNDEF_SIZE = 3'd4
    } biu_size_t;

    // Arbiter states: the BUSY state records which requester owns the bus.
    typedef logic [1:0] arb_state_t;
    localparam arb_state_t ARB_IDLE   = 2'd0;
    localparam arb_state_t ARB_BUSY_I = 2'd1;
    localparam arb_state_t ARB_BUSY_D = 2'd2;

endpackage

// File: rtl/riscv_mem_arb_timer.sv
// Bus-timeout counter: counts enabled cycles and flags the last allowed one.
module riscv_mem_arb_timer #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic expired
);

    localparam logic [15:0] LAST_CYCLE = 16'(TIMEOUT - 1);

    logic [15:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (en)
            cnt <= cnt + 16'd1;
    end

    // High during the TIMEOUT-th cycle of an outstanding request.
    assign expired = en && (cnt == LAST_CYCLE);

endmodule

// File: rtl/riscv_mem_arbiter.sv
// Two-requester (imem/dmem) arbiter onto one shared memory port.
// Define RISCV_MEM_ARB_RR_EN for round-robin instead of fixed dmem priority.
module riscv_mem_arbiter
    import riscv_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            rst,

    input  logic            imem_req,
    input  logic [XLEN-1:0] imem_adr,
    output logic            imem_ack,
    output logic [XLEN-1:0] imem_q,
    output logic            imem_err,

    input  logic            dmem_req,
    input  logic            dmem_we,
    input  biu_size_t       dmem_size,
    input  logic [XLEN-1:0] dmem_adr,
    input  logic [XLEN-1:0] dmem_d,
    output logic            dmem_ack,
    output logic [XLEN-1:0] dmem_q,
    output logic            dmem_err,

    output logic            bus_req,
    output logic            bus_we,
    output biu_size_t       bus_size,
    output logic [XLEN-1:0] bus_adr,
    output logic [XLEN-1:0] bus_d,
    input  logic            bus_ack,
    input  logic [XLEN-1:0] bus_q,
    input  logic            bus_err
);

    arb_state_t state;
    logic       busy;
    logic       expired;
    logic       rsp_ack;
    logic       rsp_err;
    logic       grant_d;
    logic       grant_i;

    assign busy    = (state != ARB_IDLE);
    // An error (or a simultaneous ack+err) beats ack; a real ack beats the timeout.
    assign rsp_err = busy && (bus_err || (expired && !bus_ack));
    assign rsp_ack = busy && bus_ack && !bus_err;

`ifdef RISCV_MEM_ARB_RR_EN
    logic last_dmem;

    // The flag only moves on contested grants, so lone requests never tilt the turn.
    assign grant_d = dmem_req && (!imem_req || !last_dmem);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            last_dmem <= 1'b0;
        else if (!busy && imem_req && dmem_req)
            last_dmem <= grant_d;
    end
`else
    assign grant_d = dmem_req;
`endif

    assign grant_i = imem_req && !grant_d;

    riscv_mem_arb_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .en      (busy),
        .clr     (!busy),
        .expired (expired)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ARB_IDLE;
            bus_req  <= 1'b0;
            bus_we   <= 1'b0;
            bus_size <= WORD;
            bus_adr  <= '0;
            bus_d    <= '0;
            imem_ack <= 1'b0;
            imem_err <= 1'b0;
            imem_q   <= '0;
            dmem_ack <= 1'b0;
            dmem_err <= 1'b0;
            dmem_q   <= '0;
        end else begin
            // NOTE: defaulting the strobes with <= first makes every ack/err a single-cycle pulse.
            imem_ack <= 1'b0;
            imem_err <= 1'b0;
            dmem_ack <= 1'b0;
            dmem_err <= 1'b0;

            case (state)
                ARB_IDLE: begin
                    if (grant_d) begin
                        state    <= ARB_BUSY_D;
                        bus_req  <= 1'b1;
                        bus_we   <= dmem_we;
                        bus_size <= dmem_size;
                        bus_adr  <= dmem_adr;
                        bus_d    <= dmem_d;
                    end else if (grant_i) begin
                        state    <= ARB_BUSY_I;
                        bus_req  <= 1'b1;
                        bus_we   <= 1'b0;
                        bus_size <= WORD;
                        bus_adr  <= imem_adr;
                    end
                end

                ARB_BUSY_I: begin
                    if (rsp_ack || rsp_err) begin
                        state    <= ARB_IDLE;
                        bus_req  <= 1'b0;
                        imem_ack <= rsp_ack;
                        imem_err <= rsp_err;
                        if (rsp_ack)
                            imem_q <= bus_q;
                    end
                end

                ARB_BUSY_D: begin
                    if (rsp_ack || rsp_err) begin
                        state    <= ARB_IDLE;
                        bus_req  <= 1'b0;
                        dmem_ack <= rsp_ack;
                        dmem_err <= rsp_err;
                        if (rsp_ack)
                            dmem_q <= bus_q;
                    end
                end

                default: begin
                    state   <= ARB_IDLE;
                    bus_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// Self-checking bench for riscv_mem_arbiter: directed scenarios plus random traffic
// against a transaction-level model of arbitration and response delivery.
module tb_riscv_mem_arbiter;
    import riscv_pkg::*;

    localparam int XLEN = 32;
    localparam int TMO  = 4;

`ifdef RISCV_MEM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst;
    logic            imem_req, imem_ack, imem_err;
    logic [XLEN-1:0] imem_adr, imem_q;
    logic            dmem_req, dmem_we, dmem_ack, dmem_err;
    biu_size_t       dmem_size;
    logic [XLEN-1:0] dmem_adr, dmem_d, dmem_q;
    logic            bus_req, bus_we, bus_ack, bus_err;
    biu_size_t       bus_size;
    logic [XLEN-1:0] bus_adr, bus_d, bus_q;

    always #5 clk = ~clk;

    riscv_mem_arbiter #(
        .XLEN    (XLEN),
        .TIMEOUT (TMO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .imem_req  (imem_req),
        .imem_adr  (imem_adr),
        .imem_ack  (imem_ack),
        .imem_q    (imem_q),
        .imem_err  (imem_err),
        .dmem_req  (dmem_req),
        .dmem_we   (dmem_we),
        .dmem_size (dmem_size),
        .dmem_adr  (dmem_adr),
        .dmem_d    (dmem_d),
        .dmem_ack  (dmem_ack),
        .dmem_q    (dmem_q),
        .dmem_err  (dmem_err),
        .bus_req   (bus_req),
        .bus_we    (bus_we),
        .bus_size  (bus_size),
        .bus_adr   (bus_adr),
        .bus_d     (bus_d),
        .bus_ack   (bus_ack),
        .bus_q     (bus_q),
        .bus_err   (bus_err)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: last data each requester received, who won the last
    // contested arbitration, and the requests present at the most recent edge.
    logic [XLEN-1:0] exp_iq, exp_dq;
    bit              last_win_d;
    bit              snap_i, snap_d;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        snap_i = imem_req;
        snap_d = dmem_req;
        @(posedge clk);
        #1;
    endtask

    task automatic new_imem(input logic [XLEN-1:0] adr);
        imem_req = 1'b1;
        imem_adr = adr;
    endtask

    task automatic new_dmem(input logic we, input biu_size_t sz,
                            input logic [XLEN-1:0] adr, input logic [XLEN-1:0] d);
        dmem_req  = 1'b1;
        dmem_we   = we;
        dmem_size = sz;
        dmem_adr  = adr;
        dmem_d    = d;
    endtask

    task automatic rand_dmem(input logic we);
        new_dmem(we, biu_size_t'(3'($urandom_range(0, 3))), $urandom, $urandom);
    endtask

    // One bus transaction. kind: 0 ack, 1 err, 2 ack+err, 3 silent slave (timeout).
    // wait_c: cycles between the first bus_req cycle and the slave's response cycle.
    task automatic do_txn(input int wait_c, input int kind, input bit d_reload,
                          input logic [XLEN-1:0] q, output int lat);
        int              n;
        bit              own_d;
        logic [XLEN-1:0] adr;
        n = 0;
        while (!bus_req && n < 4) begin
            tick();
            n++;
        end
        lat = n;
        check("grant", bus_req, 1'b1);
        if (!bus_req) return;

        own_d = snap_d && (!snap_i || !RR || !last_win_d);
        if (snap_i && snap_d) last_win_d = own_d;

        adr = own_d ? dmem_adr : imem_adr;
        check("bus_adr", bus_adr, adr);
        check("bus_we", bus_we, own_d ? dmem_we : 1'b0);
        check("bus_size", bus_size, own_d ? dmem_size : WORD);
        if (own_d) check("bus_d", bus_d, dmem_d);

        if (kind == 3) begin
            n = 0;
            while (bus_req && n < 20) begin
                tick();
                n++;
            end
            lat += n;
            check("timeout_len", n, TMO);
        end else begin
            for (int k = 0; k < wait_c; k++) begin
                tick();
                check("hold_req", bus_req, 1'b1);
                check("hold_adr", bus_adr, adr);
            end
            bus_ack = (kind == 0 || kind == 2);
            bus_err = (kind == 1 || kind == 2);
            bus_q   = q;
            tick();
            bus_ack = 1'b0;
            bus_err = 1'b0;
            lat += wait_c + 1;
            check("drop_req", bus_req, 1'b0);
        end

        if (kind == 0) begin
            if (own_d) exp_dq = q;
            else       exp_iq = q;
        end
        check("imem_ack", imem_ack, !own_d && kind == 0);
        check("imem_err", imem_err, !own_d && kind != 0);
        check("dmem_ack", dmem_ack, own_d && kind == 0);
        check("dmem_err", dmem_err, own_d && kind != 0);
        check("imem_q", imem_q, exp_iq);
        check("dmem_q", dmem_q, exp_dq);

        // The owner consumes its response; a held dmem requester issues its next load.
        if (own_d) begin
            if (d_reload) rand_dmem(1'b0);
            else          dmem_req = 1'b0;
        end else begin
            imem_req = 1'b0;
        end
        tick();
        check("pulse_end", {imem_ack, imem_err, dmem_ack, dmem_err}, 4'b0000);
        check("next_grant", bus_req, snap_i || snap_d);
    endtask

    initial begin
        int lat;
        int r;
        int kind;

        rst = 1'b1;
        imem_req = 1'b0; imem_adr = '0;
        dmem_req = 1'b0; dmem_we = 1'b0; dmem_size = WORD; dmem_adr = '0; dmem_d = '0;
        bus_ack = 1'b0; bus_err = 1'b0; bus_q = '0;
        exp_iq = '0; exp_dq = '0; last_win_d = 1'b0;
        tick();
        tick();

        check("rst_bus_req", bus_req, 1'b0);
        check("rst_bus_we", bus_we, 1'b0);
        check("rst_bus_size", bus_size, WORD);
        check("rst_bus_adr", bus_adr, '0);
        check("rst_bus_d", bus_d, '0);
        check("rst_q", {imem_q, dmem_q}, '0);
        check("rst_pulses", {imem_ack, imem_err, dmem_ack, dmem_err}, 4'b0000);
        rst = 1'b0;

        // Single fetch, slave answers one cycle after bus_req: ack three cycles after req.
        new_imem(32'h100);
        do_txn(1, 0, 1'b0, 32'h0000_0013, lat);
        check("fetch_latency", lat, 3);

        // Two simultaneous pairs: dmem store then imem; with round-robin imem leads the second pair.
        new_imem(32'h104);
        new_dmem(1'b1, WORD, 32'h200, 32'hDEAD_BEEF);
        do_txn(1, 0, 1'b0, $urandom, lat);
        do_txn(0, 0, 1'b0, $urandom, lat);
        new_imem(32'h108);
        new_dmem(1'b1, WORD, 32'h204, 32'h1234_5678);
        do_txn(2, 0, 1'b0, $urandom, lat);
        do_txn(1, 0, 1'b0, $urandom, lat);

        // Silent slave forces a timeout; then a simultaneous ack+err on a load.
        new_dmem(1'b0, WORD, 32'h300, '0);
        do_txn(0, 3, 1'b0, $urandom, lat);
        new_dmem(1'b0, HWORD, 32'h302, '0);
        do_txn(1, 2, 1'b0, $urandom, lat);

        // dmem held for three back-to-back loads while imem waits.
        new_imem(32'h400);
        rand_dmem(1'b0);
        for (int k = 0; k < 3; k++) do_txn($urandom_range(0, 2), 0, 1'b1, $urandom, lat);
        for (int k = 0; k < 4 && (imem_req || dmem_req); k++)
            do_txn($urandom_range(0, 2), 0, 1'b0, $urandom, lat);
        tick();
        check("quiet_bus", bus_req, 1'b0);

        // Reset in the middle of a dmem transaction; a late ack must be ignored.
        new_dmem(1'b0, WORD, 32'h500, '0);
        tick();
        check("pre_rst_grant", bus_req, 1'b1);
        #3 rst = 1'b1;
        #1;
        check("async_bus_req", bus_req, 1'b0);
        check("rst_dmem_ack", dmem_ack, 1'b0);
        check("rst_dmem_q", dmem_q, '0);
        check("rst_adr", bus_adr, '0);
        check("rst_size", bus_size, WORD);
        dmem_req = 1'b0;
        exp_iq = '0; exp_dq = '0; last_win_d = 1'b0;
        tick();
        rst = 1'b0;
        bus_ack = 1'b1;
        bus_q   = 32'hCAFE_F00D;
        tick();
        bus_ack = 1'b0;
        check("late_ack_ignored", {imem_ack, imem_err, dmem_ack, dmem_err}, 4'b0000);
        check("late_ack_no_req", bus_req, 1'b0);
        check("late_ack_q", dmem_q, '0);

        // Arbitration happens in the first cycle after reset is released.
        rst = 1'b1;
        new_imem(32'h600);
        tick();
        check("no_grant_in_rst", bus_req, 1'b0);
        rst = 1'b0;
        tick();
        check("first_arb", bus_req, 1'b1);
        do_txn(0, 0, 1'b0, $urandom, lat);

        // Random traffic.
        for (int it = 0; it < 40; it++) begin
            if (!imem_req && $urandom_range(0, 1) == 1) new_imem($urandom & 32'hFFFF_FFFC);
            if (!dmem_req && ($urandom_range(0, 1) == 1 || !imem_req)) rand_dmem(1'($urandom_range(0, 1)));
            r = $urandom_range(0, 9);
            kind = (r < 6) ? 0 : (r < 8) ? 1 : (r < 9) ? 2 : 3;
            do_txn($urandom_range(0, 2), kind, 1'b0, $urandom, lat);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/riscv_mem_arbiter.md
RISCV_MEM_ARBITER -- requirements
Module: riscv_mem_arbiter

Interface
REQ-001 SHALL have parameter XLEN, default 32, giving the address and data width.
REQ-002 SHALL have parameter TIMEOUT, default 255, giving the bus cycles to wait before forcing an error; range 1..65535.
REQ-003 SHALL have port clk  in  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  in  1  reset, asynchronous and active-high.
REQ-005 SHALL have ports imem_req in 1, imem_adr in XLEN, imem_ack out 1, imem_q out XLEN, imem_err out 1: the instruction-fetch requester.
REQ-006 SHALL have ports dmem_req in 1, dmem_we in 1, dmem_size in biu_size_t, dmem_adr in XLEN, dmem_d in XLEN, dmem_ack out 1, dmem_q out XLEN, dmem_err out 1: the LSU requester.
REQ-007 SHALL have ports bus_req out 1, bus_we out 1, bus_size out biu_size_t, bus_adr out XLEN, bus_d out XLEN, bus_ack in 1, bus_q in XLEN, bus_err in 1: the shared memory port.

Function
REQ-008 SHALL implement state machine IDLE, BUSY_I, BUSY_D; each requester holds req and its attributes stable until it sees its ack or err.
REQ-009 SHALL, in IDLE with any req high, register the winner's attributes onto bus_* and assert bus_req on the next cycle; state becomes BUSY_I or BUSY_D.
REQ-010 SHALL use fixed priority when both requests are high in the same cycle: dmem wins.
REQ-011 SHALL fetch imem requests with bus_we=0 and bus_size=WORD.
REQ-012 SHALL hold bus_req and all bus_* outputs constant while BUSY.
REQ-013 SHALL, on bus_ack in BUSY: drop bus_req next cycle; pulse the owner's ack for exactly 1 cycle; present bus_q on owner's q in the same cycle (registered copy).
REQ-014 SHALL, on bus_err in BUSY: pulse the owner's err for 1 cycle instead of ack; ack and err are never both high.
REQ-015 SHALL, when bus_ack and bus_err arrive together, treat the response as an error.
REQ-016 SHALL count cycles with bus_req high in a 16-bit counter; on reaching TIMEOUT with no response, drop bus_req, pulse the owner's err and return to IDLE.
REQ-017 SHALL return to IDLE after every response and re-arbitrate there, giving one idle cycle between transactions; no request is ever granted twice.
REQ-018 SHALL ignore bus_ack and bus_err in IDLE.
REQ-019 SHALL keep imem_q/dmem_q holding their last value when not acked; the non-owner's ack and err stay 0.
REQ-020 SHALL give 3-cycle minimum latency from req to ack with a 1-cycle-response slave: grant, bus_ack, ack.

Reset
REQ-021 SHALL, on rst (any time, including mid-transaction), go to IDLE asynchronously.
REQ-022 SHALL, on rst, drive bus_req=0, bus_we=0, imem_ack=0, dmem_ack=0, imem_err=0 and dmem_err=0.
REQ-023 SHALL, on rst, clear bus_adr, bus_d, imem_q, dmem_q and the timeout counter to 0, and set bus_size=WORD.
REQ-024 SHALL discard any in-flight response on reset; the first arbitration after reset is in the first cycle rst is low.

Configuration
REQ-025 SHALL, when macro RISCV_MEM_ARB_RR_EN is defined, replace fixed priority with round-robin: on a simultaneous request the requester not served last wins, with a last-served flag reset to imem.
REQ-026 SHALL, when RISCV_MEM_ARB_RR_EN is undefined, use REQ-010 fixed dmem priority and have no last-served flag.

Structure
REQ-027 SHALL take biu_size_t (BYTE, HWORD, WORD, DWORD, UNDEF_SIZE) from the shared riscv package, with the arbiter state enum added to that package.
REQ-028 SHALL place the timeout counter in sub-module riscv_mem_arb_timer (ports clk, rst, en, clr, expired); everything else is flat.

Verification
REQ-029 SHALL cover this scenario: imem_req=1, imem_adr=0x100, slave acks 1 cycle after bus_req with bus_q=0x00000013 -> bus_adr=0x100, bus_we=0, imem_ack pulses once with imem_q=0x13, 3 cycles after req.
REQ-030 SHALL cover this scenario: imem_req and dmem_req rise together, dmem store 0x200 data 0xDEADBEEF size WORD -> dmem transaction first, then imem; with RISCV_MEM_ARB_RR_EN, a second simultaneous pair serves imem first.
REQ-031 SHALL cover this scenario: TIMEOUT=4, slave never responds -> bus_req high exactly 4 cycles, dmem_err 1-cycle pulse, IDLE after.
REQ-032 SHALL cover this scenario: bus_ack and bus_err asserted together for a dmem load -> dmem_err=1, dmem_ack=0.
REQ-033 SHALL cover this scenario: rst pulsed while BUSY_D with bus_req high -> bus_req=0 asynchronously, no ack, and a late bus_ack after reset is ignored.
REQ-034 SHALL cover this scenario: dmem_req held continuously for 3 back-to-back loads with imem_req high -> with fixed priority imem starves; with RR, imem and dmem grants alternate.
